hazard_control_unit: RTL

Pipeline stall/flush controller for the 5-stage 16-bit CPU. It sits beside the forwarding logic and handles the hazards forwarding cannot resolve: load-use, taken branches/jumps resolved in EX, and multi-cycle EX operations such as mul/div. It drives the PC and pipeline-register write enables and flushes.

---
 rtl/cpu_pipe_pkg.sv | 27 ++
 rtl/hazard_perf_counters.sv | 37 +++
 rtl/hazard_control_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage 16-bit CPU: register address
// width, the hardwired-zero register, the hazard FSM state type and the
// load-use match helper.
package cpu_pipe_pkg;

  localparam int REG_ADDR_W = 3;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 3'd0;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_e;

  // True when a load in EX targets a register the ID instruction reads.
  // r0 is hardwired to zero, so a load into it is never a hazard source.
  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] ld_rd,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rt
  );
    return mem_read && (ld_rd != REG_ZERO) &&
           ((ld_rd == rs) || (uses_rt && (ld_rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating 16-bit event counters for the hazard unit: stall cycles and
// flush events. Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [15:0] stall_cycles_o,
  output logic [15:0] flush_events_o
);

  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  // Increment on each qualifying cycle, holding at all-ones.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_i && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    if (flush_i && (flush_q != 16'hFFFF)) flush_d = flush_q + 16'd1;
  end

  // Counter registers; reset clears them and blocks counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline. Handles load-use stalls,
// taken-branch flushes resolved in EX, and multi-cycle EX operations.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall/flush counters.
module hazard_control_unit
  import cpu_pipe_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] if_id_rs,
  input  logic [REG_ADDR_W-1:0] if_id_rt,
  input  logic                  if_id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_multi,
  input  logic                  ex_branch_taken,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_hold,
  output logic                  ex_mem_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_events,
`endif
  output logic                  mc_done
);

  // First BUSY cycle count: the RUN trigger cycle is stall #1, the final
  // (count==0) cycle is the done cycle.
  localparam logic [3:0] MC_START = 4'(MC_LATENCY - 2);

  hz_state_e  state_q, state_d;
  logic [3:0] mc_cnt_q, mc_cnt_d;
  logic       lu_hit;

  assign lu_hit = load_use_hit(id_ex_mem_read, id_ex_rt, if_id_rs,
                               if_id_rt, if_id_uses_rt);

  // Next state and combinational control outputs; reset forces the
  // pipeline into a flushed, frozen-PC condition.
  always_comb begin
    state_d       = state_q;
    mc_cnt_d      = mc_cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_done       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          // Redirect wins over any stall: the ID instruction is squashed anyway.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_ex_multi) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_hold       = 1'b1;
          ex_mem_bubble = 1'b1;
          mc_cnt_d      = MC_START;
          state_d       = MC_BUSY;
        end else if (lu_hit) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MC_BUSY: begin
        if (mc_cnt_q != 4'd0) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          ex_hold       = 1'b1;
          ex_mem_bubble = 1'b1;
          mc_cnt_d      = mc_cnt_q - 4'd1;
        end else begin
          mc_done = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_hold       = 1'b0;
      ex_mem_bubble = 1'b0;
      mc_done       = 1'b0;
    end
  end

  // FSM state and multi-cycle down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      mc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (~pc_write),
    .flush_i        (if_id_flush),
    .stall_cycles_o (stall_cycles),
    .flush_events_o (flush_events)
  );
`endif

endmodule
